div_iterative: RTL and testbench

- Parametrised iterative integer divider executing DIV, DIVU, REM and REMU for the execute stage.
- Successor to the fixed 32-bit radix-2 divider. Adds:
  - configurable operand width and bits retired per cycle;
  - a fast path for divide-by-zero and signed overflow;
  - a reuse cache so a DIV/REM pair on the same operands returns the second result in one cycle;
  - a pipeline kill input.
- Sits beside the multiplier in execute. Execute stalls while busy_o is high.

---
 rtl/div_iterative_pkg.sv | 23 ++
 rtl/div_iterative_step.sv | 38 +++
 rtl/div_iterative.sv | 180 ++++++++++++++++++
 tb/tb_div_iterative.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_iterative_pkg.sv
// Shared types and helpers for the iterative integer divider.
package div_iterative_pkg;

    typedef enum logic [1:0] {
        DIVS = 2'd0,
        DIVU = 2'd1,
        REMS = 2'd2,
        REMU = 2'd3
    } divOp_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_INIT = 2'd1,
        D_CALC = 2'd2,
        D_SIGN = 2'd3
    } div_states_e;

    // Only radix 2, 4 and 16 iteration hardware is supported.
    function automatic bit div_valid_radix(input int bitsPerCycle);
        return (bitsPerCycle == 1) || (bitsPerCycle == 2) || (bitsPerCycle == 4);
    endfunction

endpackage

// File: rtl/div_iterative_step.sv
// Combinational restoring-division slice: retires BITS_PER_CYCLE quotient bits, MSB first.
module div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0]           i_rem,
    input  logic [BITS_PER_CYCLE-1:0] i_bits,
    input  logic [XLEN-1:0]           i_divisor,
    output logic [XLEN-1:0]           o_rem,
    output logic [BITS_PER_CYCLE-1:0] o_qbits
);

    logic [XLEN:0]           w_trial;
    logic [XLEN:0]           w_diff;
    logic [XLEN-1:0]         w_acc;
    logic [BITS_PER_CYCLE-1:0] w_q;

    // The trial value carries one extra bit so a borrow marks a failed subtraction.
    always_comb begin
        w_trial = '0;
        w_diff  = '0;
        w_acc   = i_rem;
        w_q     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_trial = {w_acc, i_bits[BITS_PER_CYCLE-1-k]};
            w_diff  = w_trial - {1'b0, i_divisor};
            if (!w_diff[XLEN]) begin
                w_acc                   = w_diff[XLEN-1:0];
                w_q[BITS_PER_CYCLE-1-k] = 1'b1;
            end else begin
                w_acc = w_trial[XLEN-1:0];
            end
        end
        o_rem   = w_acc;
        o_qbits = w_q;
    end

endmodule

// File: rtl/div_iterative.sv
// Iterative DIV/DIVU/REM/REMU unit with fast paths, a DIV/REM reuse cache and pipeline kill.
module div_iterative
    import div_iterative_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  divOp_e          op_i,
    input  logic [XLEN-1:0] first_operand_i,
    input  logic [XLEN-1:0] second_operand_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!div_valid_radix(BITS_PER_CYCLE) || (XLEN % BITS_PER_CYCLE) != 0) begin : g_badParam
            $error("div_iterative: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
        end
    endgenerate

    div_states_e       r_state, w_nextState;
    logic              r_signed, r_isRem, r_qNeg, r_rNeg, r_fast;
    logic [XLEN-1:0]   r_dividend, r_divisor, r_absDvs, r_quo, r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cValid, r_cUnsigned;
    logic [XLEN-1:0]   r_cDvd, r_cDvs, r_cQuo, r_cRem;

    logic              w_hit, w_hitTake, w_accept;
    logic              w_dvdNeg, w_dvsNeg, w_overflow, w_divZero;
    logic [XLEN-1:0]   w_absDvd, w_absDvs, w_minVal, w_finalQ, w_finalR, w_stepRem;
    logic [BITS_PER_CYCLE-1:0] w_stepBits, w_stepQ;

    assign w_hit      = r_cValid && (r_cDvd == first_operand_i) &&
                        (r_cDvs == second_operand_i) && (r_cUnsigned == op_i[0]);
    assign w_dvdNeg   = r_signed & r_dividend[XLEN-1];
    assign w_dvsNeg   = r_signed & r_divisor[XLEN-1];
    assign w_absDvd   = w_dvdNeg ? -r_dividend : r_dividend;
    assign w_absDvs   = w_dvsNeg ? -r_divisor  : r_divisor;
    assign w_minVal   = {1'b1, {(XLEN-1){1'b0}}};
    assign w_divZero  = (r_divisor == '0);
    assign w_overflow = r_signed && (r_dividend == w_minVal) && (&r_divisor);
    assign w_stepBits = r_quo[XLEN-1 -: BITS_PER_CYCLE];
    // Fast-path results are already architecturally correct and bypass sign fix-up.
    assign w_finalQ   = (r_fast || !r_qNeg) ? r_quo : -r_quo;
    assign w_finalR   = (r_fast || !r_rNeg) ? r_rem : -r_rem;

    div_step #(
        .XLEN          (XLEN),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .i_rem    (r_rem),
        .i_bits   (w_stepBits),
        .i_divisor(r_absDvs),
        .o_rem    (w_stepRem),
        .o_qbits  (w_stepQ)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= D_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_hitTake   = 1'b0;
        if (kill_i) begin
            w_nextState = D_IDLE;
        end else begin
            case (r_state)
                D_IDLE: begin
                    if (start_i) begin
                        if (w_hit) begin
                            w_hitTake = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_nextState = D_INIT;
                        end
                    end
                end
                D_INIT:  w_nextState = (w_divZero || w_overflow) ? D_SIGN : D_CALC;
                D_CALC:  if (r_cnt == '0) w_nextState = D_SIGN;
                D_SIGN:  w_nextState = D_IDLE;
                default: w_nextState = D_IDLE;
            endcase
        end
    end

    // r_quo starts as the absolute dividend and shifts quotient bits in from the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
            r_signed    <= 1'b0;
            r_isRem     <= 1'b0;
            r_qNeg      <= 1'b0;
            r_rNeg      <= 1'b0;
            r_fast      <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_absDvs    <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_cValid    <= 1'b0;
            r_cUnsigned <= 1'b0;
            r_cDvd      <= '0;
            r_cDvs      <= '0;
            r_cQuo      <= '0;
            r_cRem      <= '0;
        end else begin
            done_o <= 1'b0;
            if (kill_i) begin
                busy_o   <= 1'b0;
                r_cValid <= 1'b0;
            end else begin
                case (r_state)
                    D_IDLE: begin
                        if (w_hitTake) begin
                            result_o <= op_i[1] ? r_cRem : r_cQuo;
                            done_o   <= 1'b1;
                        end else if (w_accept) begin
                            r_dividend <= first_operand_i;
                            r_divisor  <= second_operand_i;
                            r_signed   <= ~op_i[0];
                            r_isRem    <= op_i[1];
                            busy_o     <= 1'b1;
                        end
                    end
                    D_INIT: begin
                        r_qNeg   <= w_dvdNeg ^ w_dvsNeg;
                        r_rNeg   <= w_dvdNeg;
                        r_absDvs <= w_absDvs;
                        r_cnt    <= CNT_W'(N - 1);
                        if (w_divZero) begin
                            r_quo  <= '1;
                            r_rem  <= r_dividend;
                            r_fast <= 1'b1;
                        end else if (w_overflow) begin
                            r_quo  <= w_minVal;
                            r_rem  <= '0;
                            r_fast <= 1'b1;
                        end else begin
                            r_quo  <= w_absDvd;
                            r_rem  <= '0;
                            r_fast <= 1'b0;
                        end
                    end
                    D_CALC: begin
                        r_rem <= w_stepRem;
                        r_quo <= (r_quo << BITS_PER_CYCLE) | XLEN'(w_stepQ);
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    D_SIGN: begin
                        result_o    <= r_isRem ? w_finalR : w_finalQ;
                        done_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        r_cValid    <= 1'b1;
                        r_cUnsigned <= ~r_signed;
                        r_cDvd      <= r_dividend;
                        r_cDvs      <= r_divisor;
                        r_cQuo      <= w_finalQ;
                        r_cRem      <= w_finalR;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
// Directed-vector bench for div_iterative: radix-2 instance plus a 4-bits-per-cycle instance.
module tb_div_iterative;
    import div_iterative_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic        kill1 = 1'b0, kill4 = 1'b0;
    divOp_e      opI = DIVU;
    logic [31:0] aI = '0, bI = '0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    logic        selFast = 1'b0;
    logic        obsDone, obsBusy;
    logic [31:0] obsResult;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_iterative #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start1), .op_i(opI),
        .first_operand_i(aI), .second_operand_i(bI), .kill_i(kill1),
        .busy_o(busy1), .done_o(done1), .result_o(result1)
    );

    div_iterative #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start_i(start4), .op_i(opI),
        .first_operand_i(aI), .second_operand_i(bI), .kill_i(kill4),
        .busy_o(busy4), .done_o(done4), .result_o(result4)
    );

    assign obsDone   = selFast ? done4   : done1;
    assign obsBusy   = selFast ? busy4   : busy1;
    assign obsResult = selFast ? result4 : result1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in cycle 0, then follows it to done_o within a bounded window.
    task automatic applyStimulus(input string tag, input bit useFast, input divOp_e op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int expCycle, input logic [31:0] expResult);
        int cyc;
        int busyCnt;
        bit seen;
        selFast = useFast;
        stepCycle();
        opI = op; aI = a; bI = b;
        if (useFast) start4 = 1'b1; else start1 = 1'b1;
        stepCycle();
        start1 = 1'b0; start4 = 1'b0;
        cyc = 1; busyCnt = 0; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            if (obsBusy) busyCnt++;
            if (obsDone) seen = 1'b1;
            else begin
                stepCycle();
                cyc++;
            end
        end
        checkOutput({tag, "_cycle"}, cyc, expCycle);
        checkOutput({tag, "_result"}, obsResult, expResult);
        checkOutput({tag, "_busyCycles"}, busyCnt, expCycle - 1);
        stepCycle();
        checkOutput({tag, "_pulse"}, {31'd0, obsDone}, 32'd0);
        selFast = 1'b0;
    endtask

    initial begin
        int doneCount;
        logic [31:0] lastResult;
        int doneCycle;

        repeat (3) stepCycle();
        checkOutput("reset_busy", {31'd0, busy1}, 32'd0);
        checkOutput("reset_done", {31'd0, done1}, 32'd0);
        checkOutput("reset_result", result1, 32'd0);
        reset = 1'b0;

        applyStimulus("divu_100_7", 1'b0, DIVU, 32'd100, 32'd7, 35, 32'd14);
        applyStimulus("divu_100_7_bpc4", 1'b1, DIVU, 32'd100, 32'd7, 11, 32'd14);
        applyStimulus("divs_m7_2", 1'b0, DIVS, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFD);
        applyStimulus("rems_m7_2_hit", 1'b0, REMS, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF);

        // Kill a DIVU 100/7 in cycle 10; cache must drop the -7/2 entry too.
        doneCount = 0;
        stepCycle();
        opI = DIVU; aI = 32'd100; bI = 32'd7; start1 = 1'b1;
        stepCycle();
        start1 = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done1) doneCount++;
            stepCycle();
        end
        kill1 = 1'b1;
        stepCycle();
        kill1 = 1'b0;
        checkOutput("kill_busy", {31'd0, busy1}, 32'd0);
        checkOutput("kill_done", {31'd0, done1}, 32'd0);
        checkOutput("kill_result", result1, 32'hFFFF_FFFF);
        for (int c = 0; c < 40; c++) begin
            if (done1) doneCount++;
            stepCycle();
        end
        checkOutput("kill_noDone", doneCount, 0);

        applyStimulus("rems_m7_2_afterKill", 1'b0, REMS, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF);
        applyStimulus("remu_100_7", 1'b0, REMU, 32'd100, 32'd7, 35, 32'd2);
        applyStimulus("divu_5_0", 1'b0, DIVU, 32'd5, 32'd0, 3, 32'hFFFF_FFFF);
        applyStimulus("divs_5_0", 1'b0, DIVS, 32'd5, 32'd0, 3, 32'hFFFF_FFFF);
        applyStimulus("rems_5_0_hit", 1'b0, REMS, 32'd5, 32'd0, 1, 32'd5);
        applyStimulus("divs_min_m1", 1'b0, DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'h8000_0000);
        applyStimulus("rems_min_m1_hit", 1'b0, REMS, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        applyStimulus("divs_100_m7", 1'b0, DIVS, 32'd100, 32'hFFFF_FFF9, 35, 32'hFFFF_FFF2);
        applyStimulus("rems_100_m7_hit", 1'b0, REMS, 32'd100, 32'hFFFF_FFF9, 1, 32'd2);
        applyStimulus("remu_100_m7_miss", 1'b0, REMU, 32'd100, 32'hFFFF_FFF9, 35, 32'd100);
        applyStimulus("divs_m100_m7", 1'b0, DIVS, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 35, 32'd14);
        applyStimulus("rems_m100_m7_hit", 1'b0, REMS, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 32'hFFFF_FFFE);

        // A second start while busy must be ignored: one done_o, original operands.
        doneCount = 0; doneCycle = 0; lastResult = '0;
        stepCycle();
        opI = DIVU; aI = 32'd1000; bI = 32'd10; start1 = 1'b1;
        stepCycle();
        start1 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                opI = DIVU; aI = 32'd9; bI = 32'd3; start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            if (done1) begin
                doneCount++;
                doneCycle = c;
                lastResult = result1;
            end
            stepCycle();
        end
        start1 = 1'b0;
        checkOutput("busyStart_doneCount", doneCount, 1);
        checkOutput("busyStart_cycle", doneCycle, 35);
        checkOutput("busyStart_result", lastResult, 32'd100);

        // Reset mid-calculation clears outputs and the cache.
        stepCycle();
        opI = DIVU; aI = 32'd1000; bI = 32'd3; start1 = 1'b1;
        stepCycle();
        start1 = 1'b0;
        repeat (9) stepCycle();
        reset = 1'b1;
        stepCycle();
        checkOutput("midReset_busy", {31'd0, busy1}, 32'd0);
        checkOutput("midReset_done", {31'd0, done1}, 32'd0);
        checkOutput("midReset_result", result1, 32'd0);
        reset = 1'b0;
        applyStimulus("remu_1000_10_afterReset", 1'b0, REMU, 32'd1000, 32'd10, 35, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
